// File: rtl/data_mem_if.sv
// Memory-stage load/store responder: drives a word-wide byte-enabled
// req/gnt/rvalid bus, returns sign/zero-extended load data, and stalls the
// pipeline while a transfer is in flight.
// Optional macro MISALIGN_SPLIT_EN: when defined, accesses that cross a word
// boundary are split into two bus accesses; when undefined, they are rejected
// with a one-cycle misalign_o pulse and no bus traffic.
// Ports:
//   clk, rst (sync, active high)
//   req_i, mem_rw_i (1=store), mem_size_i (0=B 1=H 2/3=W), mem_unsigned_i
//   addr_i (byte address), wdata_i (rs2)
//   rdata_o (extended load data), stall_o, misalign_o
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i
module data_mem_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        mem_rw_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
    S_ISSUE1,
    S_WAIT1,
    S_DONE
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic        uns_q;
  logic        split_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] wbase_q;
  logic [7:0]  be_q;
  logic [63:0] wd_q;
  logic [31:0] rd0_q;
  logic [31:0] rdata_q;
`ifndef MISALIGN_SPLIT_EN
  logic        misal_q;
`endif

  // Lane placement computed from the raw request inputs.
  logic [2:0]  in_n;
  logic [3:0]  in_nmask;
  logic [7:0]  in_mask8;
  logic [63:0] in_w64;
  logic        in_split;

  always_comb begin
    in_n     = 3'd4;
    in_nmask = 4'b1111;
    case (mem_size_i)
      2'd0: begin
        in_n     = 3'd1;
        in_nmask = 4'b0001;
      end
      2'd1: begin
        in_n     = 3'd2;
        in_nmask = 4'b0011;
      end
      default: begin
        in_n     = 3'd4;
        in_nmask = 4'b1111;
      end
    endcase
    in_mask8 = {4'b0000, in_nmask} << addr_i[1:0];
    in_w64   = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
    in_split = ({1'b0, addr_i[1:0]} + in_n) > 3'd4;
  end

  // Right-align the fetched bytes, keep n bytes, then extend.
  function automatic logic [31:0] ld_ext(
    input logic [63:0] raw,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] sh;
    sh = 32'(raw >> {off, 3'b000});
    case (size)
      2'd0:    ld_ext = {{24{!uns && sh[7]}}, sh[7:0]};
      2'd1:    ld_ext = {{16{!uns && sh[15]}}, sh[15:0]};
      default: ld_ext = sh;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      wbase_q <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
`ifndef MISALIGN_SPLIT_EN
      misal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= mem_rw_i;
            uns_q   <= mem_unsigned_i;
            split_q <= in_split;
            size_q  <= mem_size_i;
            off_q   <= addr_i[1:0];
            wbase_q <= addr_i[31:2];
            be_q    <= in_mask8;
            wd_q    <= in_w64;
`ifdef MISALIGN_SPLIT_EN
            state_q <= S_ISSUE0;
`else
            if (in_split) begin
              state_q <= S_DONE;
              misal_q <= 1'b1;
              if (!mem_rw_i) rdata_q <= '0;
            end else begin
              state_q <= S_ISSUE0;
            end
`endif
          end
        end
        S_ISSUE0: begin
          if (bus_gnt_i) begin
            if (!we_q)        state_q <= S_WAIT0;
            else if (split_q) state_q <= S_ISSUE1;
            else              state_q <= S_DONE;
          end
        end
        S_WAIT0: begin
          if (bus_rvalid_i) begin
            rd0_q <= bus_rdata_i;
            if (split_q) begin
              state_q <= S_ISSUE1;
            end else begin
              state_q <= S_DONE;
              rdata_q <= ld_ext({32'b0, bus_rdata_i},
                                off_q, size_q, uns_q);
            end
          end
        end
        S_ISSUE1: begin
          if (bus_gnt_i) begin
            if (!we_q) state_q <= S_WAIT1;
            else       state_q <= S_DONE;
          end
        end
        S_WAIT1: begin
          if (bus_rvalid_i) begin
            state_q <= S_DONE;
            rdata_q <= ld_ext({bus_rdata_i, rd0_q},
                              off_q, size_q, uns_q);
          end
        end
        S_DONE: begin
          // A request presented here is only taken once back in IDLE.
          state_q <= S_IDLE;
`ifndef MISALIGN_SPLIT_EN
          misal_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic acc1;
  assign acc1 = (state_q == S_ISSUE1);

  assign bus_req_o = (state_q == S_ISSUE0) || acc1;
  assign bus_we_o  = bus_req_o && we_q;

  // Second access targets the next word; the 30-bit add wraps mod 2^32.
  assign bus_addr_o  = !bus_req_o ? 32'b0 :
                       {wbase_q + {29'b0, acc1}, 2'b00};
  assign bus_be_o    = !bus_req_o ? 4'b0 :
                       acc1 ? be_q[7:4] : be_q[3:0];
  assign bus_wdata_o = !bus_req_o ? 32'b0 :
                       acc1 ? wd_q[63:32] : wd_q[31:0];

  assign stall_o = (state_q == S_ISSUE0) || (state_q == S_WAIT0) ||
                   (state_q == S_ISSUE1) || (state_q == S_WAIT1) ||
                   ((state_q == S_IDLE) && req_i);

  assign rdata_o = rdata_q;

`ifdef MISALIGN_SPLIT_EN
  assign misalign_o = 1'b0;
`else
  assign misalign_o = misal_q;
`endif

endmodule

// File: tb/tb_data_mem_if.sv
// Scoreboard bench for data_mem_if: stimulus pushes hand-computed bus and
// completion expectations, a negedge monitor pops and compares them.
module tb_data_mem_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        mem_rw_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  always #5 clk = ~clk;

  data_mem_if dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .mem_rw_i       (mem_rw_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rdata_o        (rdata_o),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_be_o       (bus_be_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        misal;
    logic [7:0]  stall;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  bus_exp_t  mb;
  done_exp_t md;
  int checks   = 0;
  int failures = 0;
  int scnt     = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] be,
                         input logic we, input logic [31:0] wd);
    bus_q.push_back('{addr: a, be: be, we: we, wdata: wd});
  endtask

  task automatic exp_done(input logic [31:0] rd, input logic mis,
                          input logic [7:0] st);
    done_q.push_back('{rdata: rd, misal: mis, stall: st});
  endtask

  // Monitor: bus fields checked every cycle a request is held, popped on
  // gnt; completion detected as the first cycle stall falls after a run.
  always @(negedge clk) begin
    if (rst) begin
      scnt = 0;
    end else begin
      if (bus_req_o) begin
        if (bus_q.size() == 0) begin
          fail_now("bus_unexpected_req");
        end else begin
          mb = bus_q[0];
          chk("bus_addr", bus_addr_o, mb.addr);
          chk("bus_be", 32'(bus_be_o), 32'(mb.be));
          chk("bus_we", 32'(bus_we_o), 32'(mb.we));
          chk("bus_wdata", bus_wdata_o, mb.wdata);
          if (bus_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (stall_o) begin
        scnt++;
      end else begin
        if (scnt > 0) begin
          if (done_q.size() == 0) begin
            fail_now("done_unexpected");
          end else begin
            md = done_q.pop_front();
            chk("rdata", rdata_o, md.rdata);
            chk("misalign", 32'(misalign_o), 32'(md.misal));
            chk("stall_cycles", 32'(scnt), 32'(md.stall));
          end
        end else if (misalign_o) begin
          fail_now("misalign_outside_done");
        end
        scnt = 0;
      end
    end
  end

  task automatic access(input logic rw, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int nacc,
                        input int gdly, input int rvdly,
                        input logic [31:0] rd0, input logic [31:0] rd1);
    int n;
    @(posedge clk); #1;
    req_i          = 1'b1;
    mem_rw_i       = rw;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    addr_i         = addr;
    wdata_i        = wdata;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int k = 0; k < nacc; k++) begin
      n = 0;
      while (!bus_req_o && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bus_req_o) fail_now("timeout_bus_req");
      repeat (gdly) begin
        @(posedge clk); #1;
      end
      bus_gnt_i = 1'b1;
      @(posedge clk); #1;
      bus_gnt_i = 1'b0;
      if (!rw) begin
        repeat (rvdly) begin
          @(posedge clk); #1;
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = (k == 0) ? rd0 : rd1;
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
      end
    end
    n = 0;
    while (stall_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (stall_o) fail_now("timeout_stall");
    @(posedge clk); #1;
  endtask

  initial begin
    rst            = 1'b1;
    req_i          = 1'b0;
    mem_rw_i       = 1'b0;
    mem_size_i     = 2'd0;
    mem_unsigned_i = 1'b0;
    addr_i         = 32'h0;
    wdata_i        = 32'h0;
    bus_gnt_i      = 1'b0;
    bus_rvalid_i   = 1'b0;
    bus_rdata_i    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    chk("rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("rst_bus_we", 32'(bus_we_o), 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_be", 32'(bus_be_o), 32'h0);
    chk("rst_bus_wdata", bus_wdata_o, 32'h0);

    // LW 0x100
    exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
    exp_done(32'hDEADBEEF, 1'b0, 8'd3);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 0, 0,
           32'hDEADBEEF, 32'h0);

    // LB 0x203, rvalid one cycle late
    exp_bus(32'h200, 4'b1000, 1'b0, 32'h0);
    exp_done(32'hFFFFFF80, 1'b0, 8'd4);
    access(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 1, 0, 1,
           32'h80FFFFFF, 32'h0);

    // LBU 0x203
    exp_bus(32'h200, 4'b1000, 1'b0, 32'h0);
    exp_done(32'h00000080, 1'b0, 8'd3);
    access(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 1, 0, 0,
           32'h80FFFFFF, 32'h0);

    // SH 0x302, gnt delayed 2 cycles
    exp_bus(32'h300, 4'b1100, 1'b1, 32'hABCD0000);
    exp_done(32'h00000080, 1'b0, 8'd4);
    access(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000ABCD, 1, 2, 0,
           32'h0, 32'h0);

    // LHU / LH 0x402
    exp_bus(32'h400, 4'b1100, 1'b0, 32'h0);
    exp_done(32'h00008765, 1'b0, 8'd3);
    access(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 1, 0, 0,
           32'h87654321, 32'h0);
    exp_bus(32'h400, 4'b1100, 1'b0, 32'h0);
    exp_done(32'hFFFF8765, 1'b0, 8'd3);
    access(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 1, 0, 0,
           32'h87654321, 32'h0);

    // SB 0x501: whole rs2 shifted by one lane
    exp_bus(32'h500, 4'b0010, 1'b1, 32'h3456A500);
    exp_done(32'hFFFF8765, 1'b0, 8'd2);
    access(1'b1, 2'd0, 1'b0, 32'h501, 32'h123456A5, 1, 0, 0,
           32'h0, 32'h0);

    // size 3 is word; unsigned flag ignored; gnt delayed 1
    exp_bus(32'h600, 4'b1111, 1'b0, 32'h0);
    exp_done(32'h81020304, 1'b0, 8'd4);
    access(1'b0, 2'd3, 1'b1, 32'h600, 32'h0, 1, 1, 0,
           32'h81020304, 32'h0);

`ifdef MISALIGN_SPLIT_EN
    exp_bus(32'h0FFFFFFC, 4'b1100, 1'b1, 32'h33440000);
    exp_bus(32'h10000000, 4'b0011, 1'b1, 32'h00001122);
    exp_done(32'h81020304, 1'b0, 8'd3);
    access(1'b1, 2'd2, 1'b0, 32'h0FFFFFFE, 32'h11223344, 2, 0, 0,
           32'h0, 32'h0);

    exp_bus(32'h700, 4'b1110, 1'b0, 32'h0);
    exp_bus(32'h704, 4'b0001, 1'b0, 32'h0);
    exp_done(32'h44AABBCC, 1'b0, 8'd5);
    access(1'b0, 2'd2, 1'b0, 32'h701, 32'h0, 2, 0, 0,
           32'hAABBCCDD, 32'h11223344);

    exp_bus(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0);
    exp_bus(32'h00000000, 4'b0001, 1'b0, 32'h0);
    exp_done(32'h00003412, 1'b0, 8'd5);
    access(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 2, 0, 0,
           32'h12000000, 32'h00000034);

    exp_bus(32'h000, 4'b1000, 1'b1, 32'hEF000000);
    exp_bus(32'h004, 4'b0001, 1'b1, 32'h000000BE);
    exp_done(32'h00003412, 1'b0, 8'd3);
    access(1'b1, 2'd1, 1'b0, 32'h003, 32'h0000BEEF, 2, 0, 0,
           32'h0, 32'h0);
`else
    // misaligned store: no bus, rdata untouched
    exp_done(32'h81020304, 1'b1, 8'd1);
    access(1'b1, 2'd2, 1'b0, 32'h0FFFFFFE, 32'h11223344, 0, 0, 0,
           32'h0, 32'h0);

    // misaligned loads: rdata forced to 0
    exp_done(32'h00000000, 1'b1, 8'd1);
    access(1'b0, 2'd2, 1'b0, 32'h701, 32'h0, 0, 0, 0,
           32'h0, 32'h0);

    exp_done(32'h00000000, 1'b1, 8'd1);
    access(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 0, 0, 0,
           32'h0, 32'h0);

    exp_done(32'h00000000, 1'b1, 8'd1);
    access(1'b1, 2'd1, 1'b0, 32'h003, 32'h0000BEEF, 0, 0, 0,
           32'h0, 32'h0);
`endif

    // load a nonzero value so the reset case shows rdata clearing
    exp_bus(32'h900, 4'b1111, 1'b0, 32'h0);
    exp_done(32'h5A5A5A5A, 1'b0, 8'd3);
    access(1'b0, 2'd2, 1'b0, 32'h900, 32'h0, 1, 0, 0,
           32'h5A5A5A5A, 32'h0);

    // reset in WAIT0 followed by a stray rvalid
    exp_bus(32'h800, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #1;
    req_i      = 1'b1;
    mem_rw_i   = 1'b0;
    mem_size_i = 2'd2;
    addr_i     = 32'h800;
    @(posedge clk); #1;
    req_i     = 1'b0;
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    chk("rstmid_rdata", rdata_o, 32'h0);
    chk("rstmid_stall", 32'(stall_o), 32'h0);
    chk("rstmid_bus_req", 32'(bus_req_o), 32'h0);
    @(posedge clk); #1;
    chk("rstmid_rdata_hold", rdata_o, 32'h0);

    // recovery after mid-transfer reset
    exp_bus(32'hA00, 4'b1111, 1'b0, 32'h0);
    exp_done(32'h00000011, 1'b0, 8'd3);
    access(1'b0, 2'd2, 1'b0, 32'hA00, 32'h0, 1, 0, 0,
           32'h00000011, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_left", 32'(bus_q.size()), 32'h0);
    chk("done_q_left", 32'(done_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
